// File: rtl/qcl_link_pkg.sv
// Shared link definitions for the 16-lane DDR transmit framer and its receive-side aligner.
// Both ends take their training, sync and idle words from here so the two sides always agree.
package qcl_link_pkg;

    typedef enum logic [1:0] {
        TRAIN = 2'd0,
        SYNC  = 2'd1,
        RUN   = 2'd2
    } link_state_e;

    localparam int          TRAIN_CYCLES = 64;
    localparam logic [31:0] TRAIN_WORD   = 32'hFFFF_0000;
    localparam logic [31:0] SYNC_WORD    = 32'h5A5A_A5A5;
    localparam logic [31:0] IDLE_WORD    = 32'h0F0F_F0F0;

endpackage

// File: rtl/qcl_fifo_2el.sv
// Two-entry valid/ready FIFO. Zero-latency ready: ready_o depends only on the registered occupancy and on reset_i.
// A push at occupancy 2 cannot happen, because ready_o is low. A pop with a push at occupancy 1 replaces the head.
module qcl_fifo_2el (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] data_i,
    input  logic        v_i,
    output logic        ready_o,
    output logic [31:0] data_o,
    output logic        v_o,
    input  logic        yumi_i
);

    logic [31:0] head_q, head_d;
    logic [31:0] tail_q, tail_d;
    logic [1:0]  occ_q, occ_d;
    logic        push, pop;

    assign ready_o = (occ_q != 2'd2) & ~reset_i;
    assign v_o     = (occ_q != 2'd0);
    assign data_o  = head_q;
    assign push    = v_i & ready_o;
    assign pop     = yumi_i & v_o;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) head_d = data_i;
                else               tail_d = data_i;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            // Only reachable at occupancy 1: the new word becomes the head.
            2'b11: head_d = data_i;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

endmodule

// File: rtl/qcl_ddr_tx16_framer.sv
// Framer for the 16-lane DDR transmit path. It sends a training burst and then a sync word, and then sends user words or idle.
// The output word is registered and always matches the current state. A word accepted in RUN with an empty FIFO appears one cycle later.
// Backpressure: the 2-entry input FIFO accepts in every state, and ready_o drops only when the FIFO is full or reset_i is high.
module qcl_ddr_tx16_framer
    import qcl_link_pkg::*;
#(
    parameter int          train_cycles_p = TRAIN_CYCLES,
    parameter logic [31:0] train_word_p   = TRAIN_WORD,
    parameter logic [31:0] sync_word_p    = SYNC_WORD,
    parameter logic [31:0] idle_word_p    = IDLE_WORD
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        retrain_i,
    input  logic [31:0] data_i,
    input  logic        v_i,
    output logic        ready_o,
    output logic [31:0] data_par_o,
    output logic        trained_o
);

    localparam int                  cnt_w_lp  = $clog2(train_cycles_p + 1);
    localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(train_cycles_p - 1);
    localparam logic [cnt_w_lp-1:0] cnt_one_lp  = cnt_w_lp'(1);

    link_state_e          state_q, state_d;
    logic [cnt_w_lp-1:0]  count_q, count_d;
    logic [31:0]          data_q, data_d;
    logic                 trained_q, trained_d;
    logic                 fifo_vld, fifo_pop;
    logic [31:0]          fifo_dat;

    qcl_fifo_2el u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  (data_i),
        .v_i     (v_i),
        .ready_o (ready_o),
        .data_o  (fifo_dat),
        .v_o     (fifo_vld),
        .yumi_i  (fifo_pop)
    );

    // The output register is loaded with the word for the next state, so data_par_o always matches state_q.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        data_d    = data_q;
        trained_d = trained_q;
        fifo_pop  = 1'b0;
        if (retrain_i) begin
            state_d   = TRAIN;
            count_d   = '0;
            data_d    = train_word_p;
            trained_d = 1'b0;
        end else begin
            case (state_q)
                TRAIN: begin
                    trained_d = 1'b0;
                    if (count_q == cnt_last_lp) begin
                        state_d = SYNC;
                        count_d = '0;
                        data_d  = sync_word_p;
                    end else begin
                        count_d = count_q + cnt_one_lp;
                        data_d  = train_word_p;
                    end
                end
                SYNC, RUN: begin
                    state_d   = RUN;
                    trained_d = 1'b1;
                    fifo_pop  = fifo_vld;
                    data_d    = fifo_vld ? fifo_dat : idle_word_p;
                end
                default: begin
                    state_d   = TRAIN;
                    count_d   = '0;
                    data_d    = train_word_p;
                    trained_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= TRAIN;
            count_q   <= '0;
            data_q    <= train_word_p;
            trained_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            data_q    <= data_d;
            trained_q <= trained_d;
        end
    end

    assign data_par_o = data_q;
    assign trained_o  = trained_q;

endmodule

// File: tb/tb_qcl_ddr_tx16_framer.sv
// Bench for qcl_ddr_tx16_framer. Every cycle, a frame-level reference model predicts ready_o, data_par_o and trained_o.
// The model counts training words shown, keeps a word queue, and outputs the sync word and then the queued data or idle.
module tb_qcl_ddr_tx16_framer;

    localparam logic [31:0] T_WORD = 32'hFFFF_0000;
    localparam logic [31:0] S_WORD = 32'h5A5A_A5A5;
    localparam logic [31:0] I_WORD = 32'h0F0F_F0F0;
    localparam int          T_LEN  = 64;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        retrain_i = 1'b0;
    logic [31:0] data_i = '0;
    logic        v_i = 1'b0;
    logic        ready_o;
    logic [31:0] data_par_o;
    logic        trained_o;

    int checks = 0;
    int failures = 0;

    // Reference model: phase 0 = training burst, 1 = sync shown, 2 = link up.
    int          m_phase = 0;
    int          m_shown = 0;
    logic [31:0] m_q[$];
    logic [31:0] exp_data;
    logic        exp_trained;

    qcl_ddr_tx16_framer dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .retrain_i  (retrain_i),
        .data_i     (data_i),
        .v_i        (v_i),
        .ready_o    (ready_o),
        .data_par_o (data_par_o),
        .trained_o  (trained_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive one cycle: check ready, clock, advance the model, check the outputs.
    task automatic step(input logic rst, input logic rt, input logic vv, input logic [31:0] d,
                        output logic acc);
        logic exp_rdy;
        reset_i   = rst;
        retrain_i = rt;
        v_i       = vv;
        data_i    = d;
        #1;
        exp_rdy = (m_q.size() < 2) && !rst;
        chk("ready_o", {31'b0, ready_o}, {31'b0, exp_rdy});
        acc = vv && exp_rdy;
        @(posedge clk_i);
        #1;
        if (rst) begin
            m_q.delete();
            m_phase = 0; m_shown = 1; exp_data = T_WORD; exp_trained = 1'b0;
        end else begin
            if (rt) begin
                m_phase = 0; m_shown = 1; exp_data = T_WORD; exp_trained = 1'b0;
            end else if (m_phase == 0) begin
                exp_trained = 1'b0;
                if (m_shown < T_LEN) begin
                    exp_data = T_WORD; m_shown++;
                end else begin
                    exp_data = S_WORD; m_phase = 1;
                end
            end else begin
                m_phase = 2; exp_trained = 1'b1;
                if (m_q.size() > 0) exp_data = m_q.pop_front();
                else                exp_data = I_WORD;
            end
            if (acc) m_q.push_back(d);
        end
        chk("data_par_o", data_par_o, exp_data);
        chk("trained_o", {31'b0, trained_o}, {31'b0, exp_trained});
    endtask

    task automatic idle_n(input int n);
        logic a;
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, $urandom, a);
    endtask

    initial begin
        logic        a;
        logic [31:0] w;
        int          run_len;

        // 1: reset for 3 cycles, then a full training burst, sync, idle.
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, '0, a);
        chk("reset_data", data_par_o, T_WORD);
        chk("reset_trained", {31'b0, trained_o}, 32'd0);
        run_len = 1;
        while (data_par_o === T_WORD && run_len < 200) begin
            step(1'b0, 1'b0, 1'b0, '0, a);
            if (data_par_o === T_WORD) run_len++;
        end
        chk("train_len", run_len, T_LEN);
        chk("sync_word", data_par_o, S_WORD);
        idle_n(3);
        chk("idle_word", data_par_o, I_WORD);

        // 2: three back-to-back words in RUN.
        step(1'b0, 1'b0, 1'b1, 32'h1111_1111, a);
        step(1'b0, 1'b0, 1'b1, 32'h2222_2222, a);
        chk("b2b_first", data_par_o, 32'h1111_1111);
        step(1'b0, 1'b0, 1'b1, 32'h3333_3333, a);
        chk("b2b_second", data_par_o, 32'h2222_2222);
        idle_n(1);
        chk("b2b_third", data_par_o, 32'h3333_3333);
        idle_n(2);

        // 3: v_i held through training; the FIFO fills and then stalls.
        step(1'b1, 1'b0, 1'b0, '0, a);
        w = 32'hA000_0000;
        for (int k = 0; k < T_LEN + 4; k++) begin
            step(1'b0, 1'b0, 1'b1, w, a);
            if (a) w = w + 32'd1;
        end
        idle_n(4);

        // 4: retrain in RUN with one word queued.
        step(1'b0, 1'b0, 1'b1, 32'hBEEF_0001, a);
        step(1'b0, 1'b1, 1'b0, '0, a);
        chk("retrain_train", data_par_o, T_WORD);
        idle_n(T_LEN + 2);

        // 5: queue two words, then reset; they must never show up.
        step(1'b0, 1'b1, 1'b1, 32'hDEAD_0001, a);
        step(1'b0, 1'b0, 1'b1, 32'hDEAD_0002, a);
        step(1'b1, 1'b0, 1'b1, 32'hDEAD_0003, a);
        chk("reset_mid_data", data_par_o, T_WORD);
        idle_n(T_LEN + 4);

        // 6: random traffic with occasional retrain and reset.
        w = $urandom;
        for (int k = 0; k < 10000; k++) begin
            logic rst, rt, vv;
            rst = ($urandom_range(0, 1999) == 0);
            rt  = ($urandom_range(0, 249) == 0);
            vv  = ($urandom_range(0, 1) == 1);
            step(rst, rt, vv, w, a);
            if (a) w = $urandom;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
